vvalu_config_sequencer: RTL and testbench

- Controller that safely reprograms the per-chain firmware tables of a vectorVectorALU instance while tracing is live.
- Accepts a host stream of (chain, field, value) writes and stalls the upstream feed into the ALU.
- Waits for the ALU pipeline to drain, then serialises each write onto the ALU's configId/configData bus and releases the stall.
- Sits between the host config interconnect and one ALU instance.

---
 rtl/vvalu_cfg_pkg.sv | 30 +++
 rtl/vvalu_drain_monitor.sv | 43 ++++
 rtl/vvalu_config_sequencer.sv | 152 +++++++++++++++
 tb/tb_vvalu_config_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vvalu_cfg_pkg.sv
// Shared types and constants for the vectorVectorALU config sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package vvalu_cfg_pkg;

    // Width of the chain slot in a config header byte; the field id fills the top 3 bits.
    localparam int CFG_HDR_CHAIN_BITS = 5;

    typedef enum logic [2:0] {
        FIELD_OP         = 3'd0,
        FIELD_ADDR_RD    = 3'd1,
        FIELD_COND       = 3'd2,
        FIELD_CACHE      = 3'd3,
        FIELD_CACHE_ADDR = 3'd4
    } cfg_field_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_LOAD_HDR = 3'd2,
        ST_LOAD_VAL = 3'd3,
        ST_RESUME   = 3'd4
    } cfg_state_e;

    // Field ids 5..7 do not exist in the ALU firmware table.
    function automatic logic field_is_legal(input logic [2:0] field);
        return field <= 3'(FIELD_CACHE_ADDR);
    endfunction

endpackage

// File: rtl/vvalu_drain_monitor.sv
// Counts consecutive cycles with no valid entering or leaving the ALU.
// Latency: done is combinational on the cycle the count reaches DRAIN_CYCLES.
// Backpressure: none; clear holds the count at zero outside the drain window.
module vvalu_drain_monitor #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic valid_in,
    input  logic valid_out,
    output logic done
);

    localparam int CNTW = $clog2(DRAIN_CYCLES + 1);

    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_nx;

    // Any traffic restarts the window; saturate once the pipeline is known empty.
    always_comb begin
        cnt_nx = cnt;
        if (valid_in || valid_out) begin
            cnt_nx = '0;
        end else if (cnt != CNTW'(DRAIN_CYCLES)) begin
            cnt_nx = cnt + CNTW'(1);
        end
    end

    assign done = !clear && (cnt_nx == CNTW'(DRAIN_CYCLES));

    // Idle-cycle counter, parked at zero while not draining.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nx;
        end
    end

endmodule

// File: rtl/vvalu_config_sequencer.sv
// Stalls the ALU feed, waits for drain, then serialises (chain, field, value) writes as header+value on configId/configData.
// Latency: request to first header 5 cycles with an idle pipeline; 1 write per 2 cycles within a burst. Optional VVALU_CFG_SHADOW_EN.
// Backpressure: cfg_ready is high only in LOAD_HDR; a host that drops cfg_valid mid-burst leaves the stall held indefinitely.
module vvalu_config_sequencer
    import vvalu_cfg_pkg::*;
#(
    parameter int         MAX_CHAINS   = 4,
    parameter logic [7:0] TARGET_ID    = 8'd0,
    parameter logic [7:0] IDLE_ID      = 8'hFF,
    parameter int         DRAIN_CYCLES = 3,
    localparam int        CW           = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tracing_in,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_chain,
    input  logic [2:0]    cfg_field,
    input  logic [7:0]    cfg_value,
    input  logic          cfg_last,
    input  logic          alu_valid_in,
    input  logic          alu_valid_out,
    output logic          stall_out,
    output logic [7:0]    configId,
    output logic [7:0]    configData,
    output logic          cfg_busy,
`ifdef VVALU_CFG_SHADOW_EN
    input  logic [CW-1:0] rd_chain,
    input  logic [2:0]    rd_field,
    output logic [7:0]    rd_data,
`endif
    output logic          cfg_err
);

    localparam logic [2:0] S_IDLE     = ST_IDLE;
    localparam logic [2:0] S_DRAIN    = ST_DRAIN;
    localparam logic [2:0] S_LOAD_HDR = ST_LOAD_HDR;
    localparam logic [2:0] S_LOAD_VAL = ST_LOAD_VAL;
    localparam logic [2:0] S_RESUME   = ST_RESUME;

    logic [2:0] state;
    logic [2:0] state_nx;
    logic [7:0] val_q;
    logic       last_q;
    logic       drain_done;
    logic       beat_acc;
    logic       beat_legal;
    logic       shadow_hit;
    logic       beat_emit;

    assign beat_acc   = cfg_valid && cfg_ready;
    assign beat_legal = field_is_legal(cfg_field);
    assign beat_emit  = beat_legal && !shadow_hit;

    vvalu_drain_monitor #(
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_drain (
        .clk       (clk),
        .reset     (reset),
        .clear     (state != S_DRAIN),
        .valid_in  (alu_valid_in),
        .valid_out (alu_valid_out),
        .done      (drain_done)
    );

`ifdef VVALU_CFG_SHADOW_EN
    logic [7:0] shadow [MAX_CHAINS][5];
    logic [2:0] wr_idx;
    logic [2:0] rd_idx;

    // Out-of-table field ids are steered to slot 0 and then masked, so no index goes out of range.
    assign wr_idx     = beat_legal ? cfg_field : 3'd0;
    assign rd_idx     = field_is_legal(rd_field) ? rd_field : 3'd0;
    assign shadow_hit = beat_legal && (shadow[cfg_chain][wr_idx] == cfg_value);
    assign rd_data    = field_is_legal(rd_field) ? shadow[rd_chain][rd_idx] : 8'd0;

    // Mirror of what the ALU firmware tables hold after each accepted legal beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < MAX_CHAINS; c++) begin
                for (int f = 0; f < 5; f++) begin
                    shadow[c][f] <= 8'd0;
                end
            end
        end else if (beat_acc && beat_legal) begin
            shadow[cfg_chain][wr_idx] <= cfg_value;
        end
    end
`else
    assign shadow_hit = 1'b0;
`endif

    // Next-state: skipped beats (illegal or unchanged) still honour cfg_last so a burst always ends.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (cfg_valid) state_nx = S_DRAIN;
            S_DRAIN:    if (!tracing_in || drain_done) state_nx = S_LOAD_HDR;
            S_LOAD_HDR: begin
                if (beat_acc) begin
                    if (beat_emit) begin
                        state_nx = S_LOAD_VAL;
                    end else if (cfg_last) begin
                        state_nx = S_RESUME;
                    end
                end
            end
            S_LOAD_VAL: state_nx = last_q ? S_RESUME : S_LOAD_HDR;
            S_RESUME:   state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // State and all registered outputs; the bus defaults back to IDLE_ID every cycle it is not driven.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            stall_out  <= 1'b0;
            cfg_busy   <= 1'b0;
            cfg_ready  <= 1'b0;
            configId   <= IDLE_ID;
            configData <= 8'd0;
            cfg_err    <= 1'b0;
            val_q      <= 8'd0;
            last_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            stall_out  <= (state_nx != S_IDLE);
            cfg_busy   <= (state_nx != S_IDLE);
            cfg_ready  <= (state_nx == S_LOAD_HDR);
            configId   <= IDLE_ID;
            configData <= 8'd0;
            if (beat_acc) begin
                val_q  <= cfg_value;
                last_q <= cfg_last;
                if (!beat_legal) begin
                    cfg_err <= 1'b1;
                end
                if (beat_emit) begin
                    configId   <= TARGET_ID;
                    configData <= {cfg_field, CFG_HDR_CHAIN_BITS'(cfg_chain)};
                end
            end
            if (state == S_LOAD_VAL) begin
                configId   <= TARGET_ID;
                configData <= val_q;
            end
        end
    end

endmodule

// File: tb/tb_vvalu_config_sequencer.sv
// Directed bench for vvalu_config_sequencer with a bus-cycle scoreboard.
// Latency: checks exact drain/handshake timing against hand-derived cycle counts.
// Backpressure: host side holds cfg_valid until cfg_ready is seen.
module tb_vvalu_config_sequencer;

    localparam logic [7:0] TARGET_ID = 8'd0;
    localparam logic [7:0] IDLE_ID   = 8'hFF;

    logic       clk = 1'b0;
    logic       reset;
    logic       tracing_in;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_chain;
    logic [2:0] cfg_field;
    logic [7:0] cfg_value;
    logic       cfg_last;
    logic       alu_valid_in;
    logic       alu_valid_out;
    logic       stall_out;
    logic [7:0] configId;
    logic [7:0] configData;
    logic       cfg_busy;
    logic       cfg_err;
`ifdef VVALU_CFG_SHADOW_EN
    logic [1:0] rd_chain;
    logic [2:0] rd_field;
    logic [7:0] rd_data;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [15:0] exp_q [$];

    vvalu_config_sequencer #(
        .MAX_CHAINS   (4),
        .TARGET_ID    (TARGET_ID),
        .IDLE_ID      (IDLE_ID),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tracing_in    (tracing_in),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_chain     (cfg_chain),
        .cfg_field     (cfg_field),
        .cfg_value     (cfg_value),
        .cfg_last      (cfg_last),
        .alu_valid_in  (alu_valid_in),
        .alu_valid_out (alu_valid_out),
        .stall_out     (stall_out),
        .configId      (configId),
        .configData    (configData),
        .cfg_busy      (cfg_busy),
`ifdef VVALU_CFG_SHADOW_EN
        .rd_chain      (rd_chain),
        .rd_field      (rd_field),
        .rd_data       (rd_data),
`endif
        .cfg_err       (cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every non-idle bus cycle must match the next expected (id, data) pair.
    always @(negedge clk) begin
        if (reset === 1'b0 && configId !== IDLE_ID) begin
            if (exp_q.size() == 0) begin
                chk("bus_unexpected", {configId, configData}, {IDLE_ID, 8'h00});
            end else begin
                chk("bus_cycle", {configId, configData}, exp_q.pop_front());
            end
        end
    end

    // Present one beat, wait (bounded) for cfg_ready, and take the handshake edge.
    task automatic send(input logic [1:0] ch, input logic [2:0] fld, input logic [7:0] val,
                        input logic lst, input logic emits, output int waited, output int hs);
        cfg_chain = ch;
        cfg_field = fld;
        cfg_value = val;
        cfg_last  = lst;
        cfg_valid = 1'b1;
        if (emits) begin
            exp_q.push_back({TARGET_ID, fld, 5'(ch)});
            exp_q.push_back({TARGET_ID, val});
        end
        waited = 0;
        while (cfg_ready !== 1'b1 && waited < 100) begin
            step();
            waited++;
        end
        chk("ready_seen", 32'(cfg_ready), 32'd1);
        step();
        hs = cyc;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cfg_busy !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        chk("idle_reached", 32'(cfg_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, h0, h1, h2;
        reset = 1'b1;
        tracing_in = 1'b1;
        cfg_valid = 1'b0;
        cfg_chain = '0;
        cfg_field = '0;
        cfg_value = '0;
        cfg_last = 1'b0;
        alu_valid_in = 1'b0;
        alu_valid_out = 1'b0;
`ifdef VVALU_CFG_SHADOW_EN
        rd_chain = '0;
        rd_field = '0;
`endif
        step();
        step();
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_id", 32'(configId), 32'(IDLE_ID));
        chk("rst_data", 32'(configData), 32'd0);
        chk("rst_busy", 32'(cfg_busy), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        reset = 1'b0;
        step();

        // Single write, idle pipeline: drain 3 cycles, header 02, value 01, then release.
        cfg_chain = 2'd2; cfg_field = 3'd0; cfg_value = 8'h01; cfg_last = 1'b1; cfg_valid = 1'b1;
        step();
        chk("t1_stall_rise", 32'(stall_out), 32'd1);
        chk("t1_busy_rise", 32'(cfg_busy), 32'd1);
        chk("t1_ready_drain", 32'(cfg_ready), 32'd0);
        send(2'd2, 3'd0, 8'h01, 1'b1, 1'b1, w, h0);
        chk("t1_drain_wait", w, 3);
        chk("t1_hdr_id", 32'(configId), 32'(TARGET_ID));
        chk("t1_hdr_data", 32'(configData), 32'h02);
        step();
        chk("t1_val_data", 32'(configData), 32'h01);
        chk("t1_stall_val", 32'(stall_out), 32'd1);
        step();
        chk("t1_stall_fall", 32'(stall_out), 32'd0);
        chk("t1_id_idle", 32'(configId), 32'(IDLE_ID));
        chk("t1_busy_fall", 32'(cfg_busy), 32'd0);
        step();

        // Busy pipeline: traffic at drain counts 1 and 2 restarts the idle window.
        cfg_chain = 2'd1; cfg_field = 3'd1; cfg_value = 8'h33; cfg_last = 1'b1; cfg_valid = 1'b1;
        exp_q.push_back({TARGET_ID, 8'h21});
        exp_q.push_back({TARGET_ID, 8'h33});
        step();                         // enter DRAIN, count 0
        step();                         // count 1
        alu_valid_out = 1'b1; step();   // restart
        alu_valid_out = 1'b0; step();   // 1
        step();                         // 2
        alu_valid_out = 1'b1; step();   // restart
        alu_valid_out = 1'b0; step();   // 1
        step();                         // 2
        chk("t2_ready_early", 32'(cfg_ready), 32'd0);
        step();                         // 3 -> LOAD_HDR
        chk("t2_ready_late", 32'(cfg_ready), 32'd1);
        chk("t2_stall_held", 32'(stall_out), 32'd1);
        send(2'd1, 3'd1, 8'h33, 1'b1, 1'b0, w, h0);
        wait_idle();
        step();

        // Three-beat burst on chain 0: headers 00/60/80, one write per 2 cycles.
        send(2'd0, 3'd0, 8'h02, 1'b0, 1'b1, w, h0);
        chk("t3_stall_b1", 32'(stall_out), 32'd1);
        send(2'd0, 3'd3, 8'h01, 1'b0, 1'b1, w, h1);
        chk("t3_stall_b2", 32'(stall_out), 32'd1);
        send(2'd0, 3'd4, 8'h05, 1'b1, 1'b1, w, h2);
        chk("t3_stall_b3", 32'(stall_out), 32'd1);
        chk("t3_gap_1", h1 - h0, 2);
        chk("t3_gap_2", h2 - h1, 2);
        wait_idle();
        step();

        // Illegal field: accepted silently, error latched, burst still completes.
        send(2'd0, 3'd6, 8'h77, 1'b0, 1'b0, w, h0);
        chk("t4_err_set", 32'(cfg_err), 32'd1);
        chk("t4_id_quiet", 32'(configId), 32'(IDLE_ID));
        send(2'd3, 3'd2, 8'h44, 1'b1, 1'b1, w, h1);
        chk("t4_gap", h1 - h0, 1);
        wait_idle();
        chk("t4_err_sticky", 32'(cfg_err), 32'd1);
        step();

        // Reset while the header is on the bus: everything returns to reset values at once.
        exp_q.push_back({TARGET_ID, 8'h01});
        send(2'd1, 3'd0, 8'h09, 1'b1, 1'b0, w, h0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("t5_id", 32'(configId), 32'(IDLE_ID));
        chk("t5_stall", 32'(stall_out), 32'd0);
        chk("t5_busy", 32'(cfg_busy), 32'd0);
        chk("t5_err_clr", 32'(cfg_err), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Next request with tracing off skips the drain window.
        tracing_in = 1'b0;
        send(2'd2, 3'd1, 8'hA5, 1'b1, 1'b1, w, h0);
        chk("t5_notrace_wait", w, 2);
        wait_idle();
        tracing_in = 1'b1;
        step();

`ifdef VVALU_CFG_SHADOW_EN
        // Repeat of an unchanged value is accepted without bus traffic.
        send(2'd1, 3'd0, 8'h03, 1'b1, 1'b1, w, h0);
        wait_idle();
        step();
        send(2'd1, 3'd0, 8'h03, 1'b1, 1'b0, w, h0);
        chk("t6_dup_quiet", 32'(configId), 32'(IDLE_ID));
        wait_idle();
        rd_chain = 2'd1; rd_field = 3'd0;
        #1;
        chk("t6_rd_op", 32'(rd_data), 32'h03);
        rd_chain = 2'd2; rd_field = 3'd1;
        #1;
        chk("t6_rd_addr", 32'(rd_data), 32'hA5);
        rd_field = 3'd6;
        #1;
        chk("t6_rd_illegal", 32'(rd_data), 32'h00);
        step();
`endif

        step();
        chk("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
